// File: rtl/store_commit_ctrl.sv
// Commit-side sequencer for the store unit: single-cycle stores, drained AMOs,
// fences that stall speculative stores, plus a sticky drain watchdog.
//
// state       | meaning
// IDLE        | accept head op; stores/NOPs ack same cycle
// AMO_DRAIN   | AMO held until no uncommitted stores remain
// AMO_WAIT    | AMO released to the store unit, waiting for amo_ack_i
// FENCE_DRAIN | new speculative stores stalled until store buffer empty
module store_commit_ctrl #(
  parameter int unsigned DRAIN_TIMEOUT = 1024
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       cmt_valid_i,
  input  logic [1:0] cmt_op_i,
  output logic       cmt_ack_o,
  output logic       commit_o,
  input  logic       commit_ready_i,
  output logic       amo_valid_commit_o,
  input  logic       amo_ack_i,
  input  logic       no_st_pending_i,
  input  logic       store_buffer_empty_i,
  output logic       stall_st_pending_o,
  output logic       busy_o,
  output logic       timeout_o
);

  localparam int unsigned CW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(DRAIN_TIMEOUT);

  localparam logic [1:0] OP_STORE = 2'b00;
  localparam logic [1:0] OP_AMO   = 2'b01;
  localparam logic [1:0] OP_FENCE = 2'b10;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    AMO_DRAIN   = 2'd1,
    AMO_WAIT    = 2'd2,
    FENCE_DRAIN = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    commit_o           = 1'b0;
    cmt_ack_o          = 1'b0;
    amo_valid_commit_o = 1'b0;
    stall_st_pending_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmt_valid_i && !flush_i) begin
          unique case (cmt_op_i)
            OP_STORE: begin
              commit_o  = commit_ready_i;
              cmt_ack_o = commit_ready_i;
            end
            OP_AMO:   state_d = AMO_DRAIN;
            OP_FENCE: state_d = FENCE_DRAIN;
            default:  cmt_ack_o = 1'b1;
          endcase
        end
      end
      AMO_DRAIN: begin
        if (flush_i)              state_d = IDLE;
        else if (no_st_pending_i) state_d = AMO_WAIT;
      end
      // The AMO is architecturally committed here, so flush cannot abort it.
      AMO_WAIT: begin
        amo_valid_commit_o = 1'b1;
        if (amo_ack_i) begin
          cmt_ack_o = 1'b1;
          state_d   = IDLE;
        end
      end
      FENCE_DRAIN: begin
        stall_st_pending_o = 1'b1;
        if (flush_i) begin
          state_d = IDLE;
        end else if (store_buffer_empty_i) begin
          cmt_ack_o = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Watchdog restarts on every state change so each drain phase is timed alone.
  always_comb begin
    cnt_d = '0;
    if (state_q != IDLE && state_d == state_q)
      cnt_d = (cnt_q == TMO) ? cnt_q : cnt_q + CW'(1);
    timeout_d = flush_i ? 1'b0 : (timeout_q | (cnt_d == TMO));
  end

  assign busy_o    = (state_q != IDLE);
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_store_commit_ctrl.sv
// Directed bench for store_commit_ctrl: expected output vectors are queued as
// each cycle is driven and popped/checked mid-cycle.
module tb_store_commit_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       flush_i, cmt_valid_i, commit_ready_i, amo_ack_i;
  logic       no_st_pending_i, store_buffer_empty_i;
  logic [1:0] cmt_op_i;
  logic       cmt_ack_o, commit_o, amo_valid_commit_o, stall_st_pending_o;
  logic       busy_o, timeout_o;

  int total = 0;
  int bad   = 0;
  logic [5:0] sb_q[$];

  store_commit_ctrl #(.DRAIN_TIMEOUT(8)) dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .flush_i              (flush_i),
    .cmt_valid_i          (cmt_valid_i),
    .cmt_op_i             (cmt_op_i),
    .cmt_ack_o            (cmt_ack_o),
    .commit_o             (commit_o),
    .commit_ready_i       (commit_ready_i),
    .amo_valid_commit_o   (amo_valid_commit_o),
    .amo_ack_i            (amo_ack_i),
    .no_st_pending_i      (no_st_pending_i),
    .store_buffer_empty_i (store_buffer_empty_i),
    .stall_st_pending_o   (stall_st_pending_o),
    .busy_o               (busy_o),
    .timeout_o            (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Output vector order: {commit, ack, amo_valid, stall, busy, timeout}
  function automatic logic [5:0] outs();
    return {commit_o, cmt_ack_o, amo_valid_commit_o, stall_st_pending_o, busy_o, timeout_o};
  endfunction

  task automatic check_now(input string tag);
    logic [5:0] got, exp;
    got = outs();
    exp = sb_q.pop_front();
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, queue its expectation, check mid-cycle, advance.
  task automatic step(input string tag, input bit fl, input bit v, input bit [1:0] op,
                      input bit rdy, input bit ak, input bit nsp, input bit sbe,
                      input logic [5:0] e);
    flush_i = fl; cmt_valid_i = v; cmt_op_i = op; commit_ready_i = rdy;
    amo_ack_i = ak; no_st_pending_i = nsp; store_buffer_empty_i = sbe;
    sb_q.push_back(e);
    #3;
    check_now(tag);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    flush_i = 0; cmt_valid_i = 0; cmt_op_i = 2'b00; commit_ready_i = 0;
    amo_ack_i = 0; no_st_pending_i = 0; store_buffer_empty_i = 0;
    #2;
    sb_q.push_back(6'b000000);
    check_now("reset");
    #10 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // back-to-back stores, then backpressure, then retry
    for (int i = 0; i < 4; i++) step("store", 0, 1, 2'b00, 1, 0, 0, 0, 6'b110000);
    for (int i = 0; i < 2; i++) step("store_notready", 0, 1, 2'b00, 0, 0, 0, 0, 6'b000000);
    step("store_retry", 0, 1, 2'b00, 1, 0, 0, 0, 6'b110000);
    step("nop", 0, 1, 2'b11, 1, 0, 0, 0, 6'b010000);

    // AMO: 6 drain cycles, 3 wait cycles, ack with amo_ack_i; stray ack ignored in drain
    step("amo_entry", 0, 1, 2'b01, 1, 0, 0, 0, 6'b000000);
    for (int i = 0; i < 5; i++)
      step("amo_drain", 0, 1, 2'b01, 1, (i == 2), 0, 0, 6'b000010);
    step("amo_drain_exit", 0, 1, 2'b01, 1, 0, 1, 0, 6'b000010);
    step("amo_wait", 0, 1, 2'b01, 1, 0, 1, 0, 6'b001010);
    step("amo_wait", 0, 1, 2'b01, 1, 0, 1, 0, 6'b001010);
    step("amo_ack", 0, 1, 2'b01, 1, 1, 1, 0, 6'b011010);
    step("amo_done", 0, 0, 2'b00, 1, 0, 0, 0, 6'b000000);

    // FENCE held 10 cycles: watchdog (8) sets during the drain and stays sticky
    step("fence_entry", 0, 1, 2'b10, 1, 0, 0, 0, 6'b000000);
    for (int i = 1; i <= 10; i++)
      step("fence_drain", 0, 1, 2'b10, 1, 0, 0, 0, {5'b00011, 1'(i >= 9)});
    step("fence_ack", 0, 1, 2'b10, 1, 0, 0, 1, 6'b010111);
    step("tmo_sticky", 0, 0, 2'b00, 1, 0, 0, 0, 6'b000001);

    // flush in IDLE suppresses store commit and clears the watchdog next cycle
    step("flush_idle", 1, 1, 2'b00, 1, 0, 0, 0, 6'b000001);
    step("tmo_cleared", 0, 0, 2'b00, 1, 0, 0, 0, 6'b000000);

    // flush in FENCE_DRAIN: back to IDLE without ack
    step("fflush_entry", 0, 1, 2'b10, 1, 0, 0, 0, 6'b000000);
    step("fflush_drain", 0, 1, 2'b10, 1, 0, 0, 0, 6'b000110);
    step("fflush_flush", 1, 1, 2'b10, 1, 0, 0, 0, 6'b000110);
    step("fflush_idle", 0, 0, 2'b00, 1, 0, 0, 0, 6'b000000);

    // AMO with drain already satisfied, flush during AMO_WAIT is ignored
    step("aflush_entry", 0, 1, 2'b01, 1, 0, 1, 0, 6'b000000);
    step("aflush_drain1", 0, 1, 2'b01, 1, 0, 1, 0, 6'b000010);
    step("aflush_wait", 1, 1, 2'b01, 1, 0, 1, 0, 6'b001010);
    step("aflush_ack", 1, 1, 2'b01, 1, 1, 1, 0, 6'b011010);
    step("aflush_idle", 0, 0, 2'b00, 1, 0, 0, 0, 6'b000000);

    // FENCE with empty buffer on entry: exactly one drain cycle
    step("fence_fast_entry", 0, 1, 2'b10, 1, 0, 0, 1, 6'b000000);
    step("fence_fast_ack", 0, 1, 2'b10, 1, 0, 0, 1, 6'b010110);
    step("fence_fast_idle", 0, 0, 2'b00, 1, 0, 0, 1, 6'b000000);

    // stuck FENCE: timeout rises 8 cycles after entry, holds, flush clears it
    step("stuck_entry", 0, 1, 2'b10, 1, 0, 0, 0, 6'b000000);
    for (int i = 1; i <= 12; i++)
      step("stuck_drain", 0, 1, 2'b10, 1, 0, 0, 0, {5'b00011, 1'(i >= 9)});
    step("stuck_flush", 1, 1, 2'b10, 1, 0, 0, 0, 6'b000111);
    step("stuck_cleared", 0, 0, 2'b00, 1, 0, 0, 0, 6'b000000);

    // amo_ack_i in IDLE has no effect
    step("stray_amo_ack", 0, 0, 2'b00, 1, 1, 0, 0, 6'b000000);

    // reset asserted while in AMO_WAIT returns to IDLE immediately, no ack
    step("rst_amo_entry", 0, 1, 2'b01, 1, 0, 1, 0, 6'b000000);
    step("rst_amo_drain", 0, 1, 2'b01, 1, 0, 1, 0, 6'b000010);
    flush_i = 0; cmt_valid_i = 1; cmt_op_i = 2'b01; amo_ack_i = 1; no_st_pending_i = 1;
    rst_ni = 1'b0;
    #1;
    sb_q.push_back(6'b000000);
    check_now("rst_mid_amo");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    step("post_reset_idle", 0, 0, 2'b00, 1, 0, 0, 0, 6'b000000);
    step("post_reset_store", 0, 1, 2'b00, 1, 0, 0, 0, 6'b110000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
